// File: rtl/reset_seq_pkg.sv
// reset_seq_pkg: shared FSM state type and width helpers for the reset sequencer
// Contents: state_t (sequencer FSM states), idx_w (stage index width),
//           cnt_w (width of a counter that holds 0..n), max2 (larger of two ints)
package reset_seq_pkg;
  typedef enum logic [2:0] {
    ST_DELAY,
    ST_WAIT_RDY,
    ST_DONE,
    ST_ERROR,
    ST_SOFT
  } state_t;
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction
  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for asynchronous level inputs
// Ports: clk - destination clock
//        rst_n - asynchronous active-low reset, clears both flop stages
//        d - asynchronous input vector (W bits)
//        q - synchronized output, two clk edges behind d
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] r_meta;
  logic [W-1:0] r_sync;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  end
  assign q = r_sync;
endmodule

// File: rtl/reset_sequencer.sv
// reset_sequencer: releases downstream block resets one at a time with delay, ack and timeout
// Ports: clk - single rising-edge clock
//        rst_n - asynchronous active-low reset from the reset generator stage
//        soft_rst_req - synchronous level request that restarts the whole sequence
//        stage_ready - asynchronous per-stage acknowledge (synchronized internally)
//        stage_rst_n - registered active-low resets to downstream blocks
//        seq_done - all stages released and acknowledged
//        seq_err - a stage failed to acknowledge in time
//        err_stage - index of the failed stage, valid while seq_err is high
module reset_sequencer import reset_seq_pkg::*; #(
  parameter int NUM_STAGES   = 4,
  parameter int STAGE_DLY    = 16,
  parameter int TIMEOUT      = 64,
  parameter int SOFT_RST_CYC = 8
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             soft_rst_req,
  input  logic [NUM_STAGES-1:0]            stage_ready,
  output logic [NUM_STAGES-1:0]            stage_rst_n,
  output logic                             seq_done,
  output logic                             seq_err,
  output logic [idx_w(NUM_STAGES)-1:0]     err_stage
);
  localparam int IDX_W = idx_w(NUM_STAGES);
  localparam int DW    = cnt_w(max2(STAGE_DLY, SOFT_RST_CYC));
  localparam int TW    = cnt_w(TIMEOUT);
  localparam logic [DW-1:0]    DLY_LAST  = DW'(STAGE_DLY - 1);
  localparam logic [DW-1:0]    SOFT_LAST = DW'(SOFT_RST_CYC - 1);
  localparam logic [TW-1:0]    TO_LAST   = TW'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_STAGES - 1);
  state_t               r_state;
  logic [IDX_W-1:0]     r_idx;
  logic [DW-1:0]        r_cnt;
  logic [TW-1:0]        r_tcnt;
  logic [NUM_STAGES-1:0] w_rdy;
  sync_2ff #(.W(NUM_STAGES)) u_rdy_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (stage_ready),
    .q     (w_rdy)
  );
  // Soft request outranks every state transition; while it is held the FSM
  // keeps re-entering SOFT with a cleared counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_DELAY;
      r_idx       <= '0;
      r_cnt       <= '0;
      r_tcnt      <= '0;
      stage_rst_n <= '0;
      seq_done    <= 1'b0;
      seq_err     <= 1'b0;
      err_stage   <= '0;
    end else if (soft_rst_req) begin
      r_state     <= ST_SOFT;
      r_idx       <= '0;
      r_cnt       <= '0;
      r_tcnt      <= '0;
      stage_rst_n <= '0;
      seq_done    <= 1'b0;
      seq_err     <= 1'b0;
      err_stage   <= '0;
    end else begin
      case (r_state)
        ST_DELAY: begin
          if (r_cnt == DLY_LAST) begin
            stage_rst_n[r_idx] <= 1'b1;
            r_cnt              <= '0;
            r_tcnt             <= '0;
            r_state            <= ST_WAIT_RDY;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_WAIT_RDY: begin
          if (w_rdy[r_idx]) begin
            r_tcnt <= '0;
            r_cnt  <= '0;
            if (r_idx == IDX_LAST) begin
              seq_done <= 1'b1;
              r_state  <= ST_DONE;
            end else begin
              r_idx   <= r_idx + 1'b1;
              r_state <= ST_DELAY;
            end
          end else if (r_tcnt == TO_LAST) begin
            // Only the failing stage goes back into reset; earlier stages keep running.
            stage_rst_n[r_idx] <= 1'b0;
            seq_err            <= 1'b1;
            err_stage          <= r_idx;
            r_tcnt             <= '0;
            r_state            <= ST_ERROR;
          end else begin
            r_tcnt <= r_tcnt + 1'b1;
          end
        end
        ST_SOFT: begin
          if (r_cnt == SOFT_LAST) begin
            r_cnt   <= '0;
            r_state <= ST_DELAY;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: scoreboard bench for reset_sequencer release timing, timeout and soft reset
module tb_reset_sequencer;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       soft_rst_req = 1'b0;
  logic [3:0] stage_ready = 4'h0;
  logic [3:0] stage_rst_n;
  logic       seq_done;
  logic       seq_err;
  logic [1:0] err_stage;
  typedef struct {
    int         t;
    logic [3:0] v;
  } ev_t;
  ev_t sbq[$];
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int base = 0;
  reset_sequencer #(
    .NUM_STAGES(4), .STAGE_DLY(16), .TIMEOUT(64), .SOFT_RST_CYC(8)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .soft_rst_req (soft_rst_req),
    .stage_ready  (stage_ready),
    .stage_rst_n  (stage_rst_n),
    .seq_done     (seq_done),
    .seq_err      (seq_err),
    .err_stage    (err_stage)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  // Waits for the next change of stage_rst_n; at=-1 if none within lim edges.
  task automatic wait_chg(input int lim, output int at, output logic [3:0] v);
    logic [3:0] p;
    p = stage_rst_n;
    at = -1;
    v = p;
    for (int n = 0; n < lim; n++) begin
      step();
      if (stage_rst_n !== p) begin
        at = cyc - base;
        v = stage_rst_n;
        return;
      end
    end
  endtask
  task automatic restart(input logic [3:0] rdy);
    rst_n = 1'b0;
    stage_ready = rdy;
    sbq.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    base = cyc;
  endtask
  task automatic test_reset();
    repeat (2) step();
    checks++;
    if (stage_rst_n !== 4'h0) begin errors++; $display("FAIL reset_stage_rst_n: got %b want 0000", stage_rst_n); end
    checks++;
    if (seq_done !== 1'b0) begin errors++; $display("FAIL reset_seq_done: got %b want 0", seq_done); end
    checks++;
    if (seq_err !== 1'b0) begin errors++; $display("FAIL reset_seq_err: got %b want 0", seq_err); end
    checks++;
    if (err_stage !== 2'd0) begin errors++; $display("FAIL reset_err_stage: got %0d want 0", err_stage); end
  endtask
  task automatic test_nominal();
    ev_t e;
    int at;
    logic [3:0] v;
    restart(4'hF);
    for (int k = 0; k < 4; k++) sbq.push_back('{16 + 17 * k, 4'((1 << (k + 1)) - 1)});
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      wait_chg(200, at, v);
      checks++;
      if (at !== e.t || v !== e.v) begin
        errors++;
        $display("FAIL nominal_release: edge %0d val %b, want edge %0d val %b", at, v, e.t, e.v);
      end
    end
    checks++;
    if (seq_done !== 1'b0) begin errors++; $display("FAIL nominal_done_early: seq_done=%b at last release, want 0", seq_done); end
    step();
    checks++;
    if (seq_done !== 1'b1 || seq_err !== 1'b0 || cyc - base !== 68) begin
      errors++;
      $display("FAIL nominal_done: edge %0d done=%b err=%b, want edge 68 done=1 err=0", cyc - base, seq_done, seq_err);
    end
  endtask
  task automatic test_late_ack();
    ev_t e;
    int at;
    int t;
    logic [3:0] v;
    restart(4'b1101);
    sbq.push_back('{16, 4'b0001});
    sbq.push_back('{33, 4'b0011});
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      wait_chg(200, at, v);
      checks++;
      if (at !== e.t || v !== e.v) begin
        errors++;
        $display("FAIL late_early_release: edge %0d val %b, want edge %0d val %b", at, v, e.t, e.v);
      end
    end
    repeat (20) @(posedge clk);
    @(negedge clk);
    stage_ready = 4'hF;
    t = cyc - base;
    // 2 synchronizer edges, 1 edge leaving WAIT_RDY, then STAGE_DLY edges of delay.
    sbq.push_back('{t + 2 + 1 + 16, 4'b0111});
    sbq.push_back('{t + 2 + 1 + 16 + 17, 4'b1111});
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      wait_chg(200, at, v);
      checks++;
      if (at !== e.t || v !== e.v) begin
        errors++;
        $display("FAIL late_release: edge %0d val %b, want edge %0d val %b", at, v, e.t, e.v);
      end
    end
    step();
    checks++;
    if (seq_done !== 1'b1 || seq_err !== 1'b0) begin
      errors++;
      $display("FAIL late_done: done=%b err=%b, want done=1 err=0", seq_done, seq_err);
    end
  endtask
  task automatic test_timeout();
    ev_t e;
    int at;
    int bad;
    logic [3:0] v;
    restart(4'b1011);
    sbq.push_back('{16, 4'b0001});
    sbq.push_back('{33, 4'b0011});
    sbq.push_back('{50, 4'b0111});
    sbq.push_back('{50 + 64, 4'b0011});
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      wait_chg(200, at, v);
      checks++;
      if (at !== e.t || v !== e.v) begin
        errors++;
        $display("FAIL timeout_event: edge %0d val %b, want edge %0d val %b", at, v, e.t, e.v);
      end
    end
    checks++;
    if (seq_err !== 1'b1 || err_stage !== 2'd2 || seq_done !== 1'b0) begin
      errors++;
      $display("FAIL timeout_flags: err=%b stage=%0d done=%b, want err=1 stage=2 done=0", seq_err, err_stage, seq_done);
    end
    bad = 0;
    repeat (200) begin
      step();
      if (stage_rst_n !== 4'b0011 || seq_err !== 1'b1 || err_stage !== 2'd2 || seq_done !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL timeout_hold: %0d cycles left ERROR hold, want 0", bad); end
  endtask
  task automatic test_soft_from_error();
    ev_t e;
    int at;
    int e0;
    logic [3:0] v;
    @(negedge clk);
    soft_rst_req = 1'b1;
    stage_ready = 4'hF;
    e0 = cyc - base + 1;
    step();
    checks++;
    if (stage_rst_n !== 4'h0 || seq_err !== 1'b0 || err_stage !== 2'd0) begin
      errors++;
      $display("FAIL soft_err_clear: rst_n=%b err=%b stage=%0d, want 0000 0 0", stage_rst_n, seq_err, err_stage);
    end
    @(negedge clk);
    soft_rst_req = 1'b0;
    for (int k = 0; k < 4; k++) sbq.push_back('{e0 + 8 + 16 + 17 * k, 4'((1 << (k + 1)) - 1)});
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      wait_chg(200, at, v);
      checks++;
      if (at !== e.t || v !== e.v) begin
        errors++;
        $display("FAIL soft_err_release: edge %0d val %b, want edge %0d val %b", at, v, e.t, e.v);
      end
    end
    step();
    checks++;
    if (seq_done !== 1'b1 || seq_err !== 1'b0) begin
      errors++;
      $display("FAIL soft_err_done: done=%b err=%b, want done=1 err=0", seq_done, seq_err);
    end
  endtask
  task automatic test_soft_held_done();
    ev_t e;
    int at;
    int e0;
    logic [3:0] v;
    @(negedge clk);
    soft_rst_req = 1'b1;
    e0 = cyc - base + 1;
    step();
    checks++;
    if (seq_done !== 1'b0 || stage_rst_n !== 4'h0) begin
      errors++;
      $display("FAIL soft_held_clear: done=%b rst_n=%b, want 0 0000", seq_done, stage_rst_n);
    end
    repeat (4) step();
    @(negedge clk);
    soft_rst_req = 1'b0;
    // Last sampled request at edge e0+4, then 8 SOFT edges, then 16 DELAY edges.
    for (int k = 0; k < 4; k++) sbq.push_back('{e0 + 4 + 8 + 16 + 17 * k, 4'((1 << (k + 1)) - 1)});
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      wait_chg(200, at, v);
      checks++;
      if (at !== e.t || v !== e.v) begin
        errors++;
        $display("FAIL soft_held_release: edge %0d val %b, want edge %0d val %b", at, v, e.t, e.v);
      end
    end
    step();
    checks++;
    if (seq_done !== 1'b1 || seq_err !== 1'b0) begin
      errors++;
      $display("FAIL soft_held_done: done=%b err=%b, want done=1 err=0", seq_done, seq_err);
    end
  endtask
  task automatic test_async_reset();
    ev_t e;
    int at;
    logic [3:0] v;
    restart(4'b1101);
    sbq.push_back('{16, 4'b0001});
    sbq.push_back('{33, 4'b0011});
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      wait_chg(200, at, v);
      checks++;
      if (at !== e.t || v !== e.v) begin
        errors++;
        $display("FAIL async_pre_release: edge %0d val %b, want edge %0d val %b", at, v, e.t, e.v);
      end
    end
    repeat (5) step();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (stage_rst_n !== 4'h0 || seq_done !== 1'b0 || seq_err !== 1'b0) begin
      errors++;
      $display("FAIL async_clear: rst_n=%b done=%b err=%b, want 0000 0 0", stage_rst_n, seq_done, seq_err);
    end
    restart(4'hF);
    for (int k = 0; k < 4; k++) sbq.push_back('{16 + 17 * k, 4'((1 << (k + 1)) - 1)});
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      wait_chg(200, at, v);
      checks++;
      if (at !== e.t || v !== e.v) begin
        errors++;
        $display("FAIL async_replay_release: edge %0d val %b, want edge %0d val %b", at, v, e.t, e.v);
      end
    end
    step();
    checks++;
    if (seq_done !== 1'b1 || cyc - base !== 68) begin
      errors++;
      $display("FAIL async_replay_done: edge %0d done=%b, want edge 68 done=1", cyc - base, seq_done);
    end
  endtask
  initial begin
    test_reset();
    test_nominal();
    test_late_ack();
    test_timeout();
    test_soft_from_error();
    test_soft_held_done();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
